// File: rtl/rv32v_types_pkg.sv
// Shared vector-unit types: lane count and element load encodings.
// Load encodings follow the RV32 funct3 field for loads.
package rv32v_types_pkg;

   localparam int NUM_LANES = 4;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_t;

   function automatic logic load_is_signed(input load_t t);
      return (t == LB) || (t == LH);
   endfunction

endpackage

// File: rtl/rv32v_load_extend.sv
// Element extraction from a cache word and sign/zero extension.
// Purely combinational; byte_off selects the byte or halfword.
module rv32v_load_extend
   import rv32v_types_pkg::*;
(
   input  load_t       load_type,
   input  logic [1:0]  byte_off,
   input  logic [31:0] raw,
   output logic [31:0] data
);

   logic [31:0] shifted;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic        sext;

   always_comb begin
      shifted = raw >> {byte_off, 3'b000};
      byte_v  = shifted[7:0];
      half_v  = byte_off[1] ? raw[31:16] : raw[15:0];
      sext    = load_is_signed(load_type);
      data    = raw;
      unique case (1'b1)
         (load_type == LB),
         (load_type == LBU):
            data = {{24{sext & byte_v[7]}}, byte_v};
         (load_type == LH),
         (load_type == LHU):
            data = {{16{sext & half_v[15]}}, half_v};
         default:
            data = raw;
      endcase
   end

endmodule

// File: rtl/rv32v_load_collector.sv
// Collects per-lane load responses for one vector load uop and
// pulses wb_valid once every unmasked lane has been written.
module rv32v_load_collector
   import rv32v_types_pkg::*;
#(
   parameter  int LANES  = NUM_LANES,
   localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   start,
   input  logic [LANES-1:0]       vlane_mask,
   input  logic [LANES-1:0][31:0] vold_data,
   input  load_t                  vload_type,
   input  logic                   rsp_valid,
   input  logic [LIDX_W-1:0]      rsp_lane,
   input  logic [1:0]             rsp_byte_off,
   input  logic [31:0]            rsp_data,
   input  logic                   flush,
   output logic [LANES-1:0][31:0] vlane_load_data,
   output logic                   wb_valid,
   output logic                   busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [LANES-1:0]       pending_q, pending_d;
   logic [LANES-1:0][31:0] result_q, result_d;
   load_t                  type_q, type_d;
   logic [31:0]            ext_data;

   rv32v_load_extend u_ext (
      .load_type (type_q),
      .byte_off  (rsp_byte_off),
      .raw       (rsp_data),
      .data      (ext_data)
   );

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      result_d  = result_q;
      type_d    = type_q;
      wb_valid  = 1'b0;
      busy      = (state_q != IDLE);
      if (flush) begin
         // result buffer is left as-is; only the uop is abandoned
         state_d   = IDLE;
         pending_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  type_d    = vload_type;
                  result_d  = vold_data;
                  pending_d = vlane_mask;
                  state_d   = (|vlane_mask) ? COLLECT : DONE;
               end
            end
            COLLECT: begin
               if (rsp_valid && pending_q[rsp_lane]) begin
                  result_d[rsp_lane]  = ext_data;
                  pending_d[rsp_lane] = 1'b0;
                  if (pending_d == '0)
                     state_d = DONE;
               end
            end
            DONE: begin
               wb_valid = 1'b1;
               state_d  = IDLE;
            end
            default: begin
               state_d   = IDLE;
               pending_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q   <= IDLE;
         pending_q <= '0;
         result_q  <= '0;
         type_q    <= LW;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         result_q  <= result_d;
         type_q    <= type_d;
      end
   end

   assign vlane_load_data = result_q;

endmodule

// File: tb/tb_rv32v_load_collector.sv
// Directed bench for rv32v_load_collector with a per-cycle
// behavioural model and literal spot checks.
module tb_rv32v_load_collector;
   import rv32v_types_pkg::*;

   localparam int L = 2;

   logic              CLK = 1'b0;
   logic              nRST;
   logic              start;
   logic [L-1:0]      vlane_mask;
   logic [L-1:0][31:0] vold_data;
   load_t             vload_type;
   logic              rsp_valid;
   logic [0:0]        rsp_lane;
   logic [1:0]        rsp_byte_off;
   logic [31:0]       rsp_data;
   logic              flush;
   logic [L-1:0][31:0] vlane_load_data;
   logic              wb_valid;
   logic              busy;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   rv32v_load_collector #(.LANES(L)) dut (
      .CLK             (CLK),
      .nRST            (nRST),
      .start           (start),
      .vlane_mask      (vlane_mask),
      .vold_data       (vold_data),
      .vload_type      (vload_type),
      .rsp_valid       (rsp_valid),
      .rsp_lane        (rsp_lane),
      .rsp_byte_off    (rsp_byte_off),
      .rsp_data        (rsp_data),
      .flush           (flush),
      .vlane_load_data (vlane_load_data),
      .wb_valid        (wb_valid),
      .busy            (busy)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit                 m_active, m_done;
   logic [L-1:0]       m_pend;
   logic [L-1:0][31:0] m_res;
   load_t              m_type;

   function automatic logic [31:0] m_ext(load_t t, int off,
                                         logic [31:0] d);
      longint unsigned w, b, h;
      w = d;
      b = (w >> (8 * off)) % 256;
      h = (w >> (16 * (off / 2))) % 65536;
      case (t)
         LB:  return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
         LBU: return 32'(b);
         LH:  return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
         LHU: return 32'(h);
         default: return d;
      endcase
   endfunction

   always @(posedge CLK) begin
      if (!nRST) begin
         m_active = 0; m_done = 0; m_pend = '0; m_res = '0;
      end else if (flush) begin
         m_active = 0; m_done = 0; m_pend = '0;
      end else if (m_done) begin
         m_done = 0;
      end else if (!m_active) begin
         if (start) begin
            m_res  = vold_data;
            m_type = vload_type;
            m_pend = vlane_mask;
            if (vlane_mask == '0) m_done = 1;
            else m_active = 1;
         end
      end else if (rsp_valid && m_pend[rsp_lane]) begin
         m_res[rsp_lane]  = m_ext(m_type, int'(rsp_byte_off), rsp_data);
         m_pend[rsp_lane] = 1'b0;
         if (m_pend == '0) begin
            m_active = 0;
            m_done   = 1;
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         check("model_data", vlane_load_data, m_res);
         check("model_wb", 64'(wb_valid), 64'(m_done && !flush));
         check("model_busy", 64'(busy), 64'(m_active || m_done));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic go(input logic [L-1:0] m, input load_t t,
                     input logic [31:0] o1, input logic [31:0] o0);
      start = 1; vlane_mask = m; vload_type = t;
      vold_data = {o1, o0};
      cyc();
      start = 0;
   endtask

   task automatic rsp(input int lane, input int off,
                      input logic [31:0] d);
      rsp_valid = 1; rsp_lane = 1'(lane);
      rsp_byte_off = 2'(off); rsp_data = d;
      cyc();
      rsp_valid = 0;
   endtask

   initial begin
      nRST = 0; start = 0; vlane_mask = '0; vold_data = '0;
      vload_type = LW; rsp_valid = 0; rsp_lane = '0;
      rsp_byte_off = '0; rsp_data = '0; flush = 0;
      cyc(); cyc();
      chk_en = 1;
      check("rst_data", vlane_load_data, 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_wb", 64'(wb_valid), 64'h0);
      nRST = 1;
      cyc();

      // two-lane word load
      go(2'b11, LW, 32'h0, 32'h0);
      check("lw_busy", 64'(busy), 64'h1);
      rsp(0, 0, 32'h1122_3344);
      check("lw_wb_early", 64'(wb_valid), 64'h0);
      rsp(1, 0, 32'hAABB_CCDD);
      check("lw_wb", 64'(wb_valid), 64'h1);
      check("lw_data", vlane_load_data, 64'hAABBCCDD_11223344);
      cyc();
      check("lw_wb_end", 64'(wb_valid), 64'h0);
      cyc();
      check("idle_hold", vlane_load_data, 64'hAABBCCDD_11223344);

      // byte loads, signed vs unsigned
      go(2'b01, LB, 32'h5555_5555, 32'h0);
      rsp(0, 3, 32'h80FF_FFFF);
      check("lb_data", vlane_load_data, 64'h55555555_FFFFFF80);
      cyc();
      go(2'b01, LBU, 32'h5555_5555, 32'h0);
      rsp(0, 3, 32'h80FF_FFFF);
      check("lbu_data", vlane_load_data, 64'h55555555_00000080);
      cyc();

      // masked lane0 keeps old data, halfword load
      go(2'b10, LH, 32'h0, 32'hDEAD_BEEF);
      rsp(1, 2, 32'h7FFF_0000);
      check("lh_wb", 64'(wb_valid), 64'h1);
      check("lh_data", vlane_load_data, 64'h00007FFF_DEADBEEF);
      cyc();
      go(2'b11, LHU, 32'h0, 32'h0);
      rsp(0, 0, 32'h8000_9234);
      rsp(1, 2, 32'h8000_1234);
      check("lhu_data", vlane_load_data, 64'h00008000_00009234);
      cyc();
      go(2'b01, LH, 32'h0, 32'h0);
      rsp(0, 2, 32'h8000_1234);
      check("lh_neg", vlane_load_data, 64'h0_FFFF8000);
      cyc();

      // all-masked uop
      go(2'b00, LW, 32'hCAFE_F00D, 32'h0123_4567);
      check("m0_wb", 64'(wb_valid), 64'h1);
      check("m0_data", vlane_load_data, 64'hCAFEF00D_01234567);
      cyc();
      check("m0_wb_end", 64'(wb_valid), 64'h0);

      // flush mid-uop, then a normal uop
      go(2'b11, LW, 32'h0, 32'h0);
      rsp(0, 0, 32'h1357_9BDF);
      flush = 1;
      cyc();
      flush = 0;
      check("fl_busy", 64'(busy), 64'h0);
      check("fl_wb", 64'(wb_valid), 64'h0);
      rsp(1, 0, 32'hFFFF_FFFF);
      cyc();
      go(2'b11, LW, 32'h0, 32'h0);
      rsp(1, 0, 32'h2222_2222);
      rsp(0, 0, 32'h1111_1111);
      check("post_fl_wb", 64'(wb_valid), 64'h1);
      cyc();

      // flush during the writeback cycle suppresses wb_valid
      go(2'b01, LW, 32'h0, 32'h0);
      rsp(0, 0, 32'h0BAD_0BAD);
      flush = 1;
      #1;
      check("fl_done_wb", 64'(wb_valid), 64'h0);
      cyc();
      flush = 0;
      cyc();

      // duplicate response and start ignored while collecting
      go(2'b11, LW, 32'h0, 32'h0);
      rsp(0, 0, 32'h0000_1111);
      rsp(0, 0, 32'h0000_2222);
      check("dup_wb", 64'(wb_valid), 64'h0);
      go(2'b00, LW, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("ign_start", 64'(wb_valid), 64'h0);
      rsp(1, 0, 32'h0000_3333);
      check("dup_wb2", 64'(wb_valid), 64'h1);
      check("dup_data", vlane_load_data, 64'h00003333_00001111);
      cyc();

      // reset mid-collect discards everything
      go(2'b11, LW, 32'h7777_7777, 32'h6666_6666);
      rsp(0, 0, 32'h4444_4444);
      nRST = 0;
      cyc();
      nRST = 1;
      check("rst_mid_data", vlane_load_data, 64'h0);
      check("rst_mid_busy", 64'(busy), 64'h0);
      rsp(1, 0, 32'h5555_5555);
      check("rst_mid_wb", 64'(wb_valid), 64'h0);
      cyc(); cyc();

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
